// File: rtl/decoder_pkg.sv
// Shared constants, state encoding and helpers for the 4-to-2 sequential encoder.
package decoder_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Number of set bits in a request vector.
  function automatic int unsigned popcount(input logic [N_REQ-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder4to2_seq_if.sv
// Request/grant bundle between the encoder and its producer/consumer.
interface encoder4to2_seq_if;
  import decoder_pkg::*;

  logic [N_REQ-1:0] D;
  logic             ready;
  logic [IDX_W-1:0] A;
  logic             valid;
  logic [N_REQ-1:0] pend;
  logic             multi;
  logic             drop;

  modport master (
    output D, ready,
    input  A, valid, pend, multi, drop
  );

  modport slave (
    input  D, ready,
    output A, valid, pend, multi, drop
  );

endinterface

// File: rtl/encoder4to2_sel.sv
// Combinational grant selector: fixed priority (index 3 highest) or
// round-robin starting just above the last accepted index.
module encoder4to2_sel
  import decoder_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan in reverse preference order so the most preferred hit is written last.
  always_comb begin
    index = '0;
    cand  = '0;
    any   = |pend;
    if (RR == 0) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (pend[i]) index = IDX_W'(i);
      end
    end else begin
      // k = N_REQ wraps to last itself (least preferred); k = 1 is last+1.
      for (int unsigned k = N_REQ; k >= 1; k--) begin
        cand = last + IDX_W'(k);
        if (pend[cand]) index = cand;
      end
    end
  end

endmodule

// File: rtl/encoder4to2_seq.sv
// Sequential 4-to-2 encoder: sticky pending requests, registered grant with
// valid/ready handshake, duplicate-request drop pulse and multi-pending flag.
module encoder4to2_seq
  import decoder_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  encoder4to2_seq_if.slave bus
);

  state_t           state;
  logic [IDX_W-1:0] a_q;
  logic [IDX_W-1:0] last_q;
  logic             valid_q;
  logic             drop_q;
  logic [N_REQ-1:0] pend_q;

  logic             accept;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] remaining;
  logic [IDX_W-1:0] sel_last;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

  // Accepted bit is removed before selection; same-edge arrivals are not
  // eligible yet. In IDLE nothing is cleared, so remaining equals pend and a
  // single selector serves both the first grant and the back-to-back reload.
  always_comb begin
    accept    = (state == HOLD) && bus.ready;
    clr_mask  = accept ? (N_REQ'(1) << a_q) : '0;
    remaining = pend_q & ~clr_mask;
    sel_last  = accept ? a_q : last_q;
  end

  encoder4to2_sel #(.RR(RR)) u_sel (
    .pend  (remaining),
    .last  (sel_last),
    .index (sel_idx),
    .any   (sel_any)
  );

  // Grant FSM with pending register, drop detection and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      pend_q  <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      // Set wins over clear: a same-edge arrival on the accepted bit re-pends it.
      pend_q <= remaining | bus.D;
      drop_q <= |(bus.D & remaining);
      case (state)
        IDLE: begin
          if (sel_any) begin
            a_q     <= sel_idx;
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            last_q <= a_q;
            if (sel_any) begin
              a_q <= sel_idx;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A     = a_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.drop  = drop_q;
  assign bus.multi = (popcount(pend_q) > 1);

endmodule
